// File: rtl/hist_accum_ctrl.sv
// Multi-lane histogram engine: streams packed pixel words, bins LANES pixels per cycle,
// then drains and clears the counter array. Define HIST_SAT_EN for saturating counters (default: wrap).
module hist_accum_ctrl #(
  parameter int LANES  = 4,
  parameter int PIX_W  = 8,
  parameter int BIN_W  = 6,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      num_words,
  output logic                   pix_rd_en,
  output logic [ADDR_W-1:0]      pix_addr,
  input  logic [LANES*PIX_W-1:0] pix_data,
  output logic                   hist_we,
  output logic [BIN_W-1:0]       hist_addr,
  output logic [CNT_W-1:0]       hist_data,
  output logic                   busy,
  output logic                   done
);

  localparam int NBINS = 1 << BIN_W;
  localparam int INC_W = $clog2(LANES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  num_q, num_d, pix_addr_d;
  logic               pix_rd_en_d, hist_we_d, busy_d, done_d;
  logic [BIN_W-1:0]   hist_addr_d;
  logic [CNT_W-1:0]   hist_data_d;
  logic               clr_en;
  logic [BIN_W-1:0]   clr_bin;
  logic               vld_p0;
  logic [INC_W-1:0]   inc     [NBINS];
  logic [CNT_W-1:0]   cnt     [NBINS];
  logic [CNT_W-1:0]   cnt_nxt [NBINS];
  logic               unused_pix;

  // Low pixel bits below the bin field do not affect binning.
  assign unused_pix = ^pix_data;

  function automatic logic [CNT_W-1:0] add_cnt(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
`ifdef HIST_SAT_EN
    logic [CNT_W+INC_W-1:0] s;
    s = (CNT_W+INC_W)'(a) + (CNT_W+INC_W)'(b);
    if (|s[CNT_W+INC_W-1:CNT_W]) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
`else
    return a + CNT_W'(b);
`endif
  endfunction

  // Stage p0: pix_data returned for the read issued last cycle; count lane hits per bin.
  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      inc[b] = '0;
      if (vld_p0) begin
        for (int l = 0; l < LANES; l++) begin
          if (pix_data[l*PIX_W + PIX_W - BIN_W +: BIN_W] == BIN_W'(b))
            inc[b] = inc[b] + INC_W'(1);
        end
      end
      cnt_nxt[b] = add_cnt(cnt[b], inc[b]);
    end
  end

  always_comb begin
    state_d     = state;
    num_d       = num_q;
    pix_rd_en_d = 1'b0;
    pix_addr_d  = '0;
    hist_we_d   = 1'b0;
    hist_addr_d = '0;
    hist_data_d = '0;
    done_d      = 1'b0;
    clr_en      = 1'b0;
    clr_bin     = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          num_d = num_words;
          if (num_words != '0) begin
            state_d     = S_ACCUM;
            pix_rd_en_d = 1'b1;
          end else begin
            state_d     = S_WRITE;
            hist_we_d   = 1'b1;
            hist_data_d = cnt_nxt[0];
            clr_en      = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (pix_addr == num_q - ADDR_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          pix_rd_en_d = 1'b1;
          pix_addr_d  = pix_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Bin 0 is captured here so it already includes the final returned word.
        state_d     = S_WRITE;
        hist_we_d   = 1'b1;
        hist_data_d = cnt_nxt[0];
        clr_en      = 1'b1;
      end
      S_WRITE: begin
        if (&hist_addr) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          hist_we_d   = 1'b1;
          hist_addr_d = hist_addr + BIN_W'(1);
          hist_data_d = cnt_nxt[hist_addr_d];
          clr_en      = 1'b1;
          clr_bin     = hist_addr_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      num_q     <= '0;
      pix_rd_en <= 1'b0;
      pix_addr  <= '0;
      hist_we   <= 1'b0;
      hist_addr <= '0;
      hist_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      state     <= state_d;
      num_q     <= num_d;
      pix_rd_en <= pix_rd_en_d;
      pix_addr  <= pix_addr_d;
      hist_we   <= hist_we_d;
      hist_addr <= hist_addr_d;
      hist_data <= hist_data_d;
      busy      <= busy_d;
      done      <= done_d;
      vld_p0    <= pix_rd_en;
    end
  end

  // A bin is zeroed on the edge its final count is handed to hist_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBINS; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NBINS; b++)
        cnt[b] <= (clr_en && clr_bin == BIN_W'(b)) ? '0 : cnt_nxt[b];
    end
  end

endmodule

// File: tb/tb_hist_accum_ctrl.sv
// Bench for hist_accum_ctrl: default instance plus a CNT_W=3 instance for overflow behaviour,
// both checked against a per-run histogram model computed from the pixel memory contents.
module tb_hist_accum_ctrl;
  localparam int LANES = 4, PIX_W = 8, BIN_W = 6, CNT_W = 16, ADDR_W = 14;
  localparam int NBINS = 64, SCW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start, pix_rd_en, hist_we, busy, done;
  logic [ADDR_W-1:0] num_words, pix_addr;
  logic [31:0]       pix_data;
  logic [BIN_W-1:0]  hist_addr;
  logic [CNT_W-1:0]  hist_data;

  logic              s_start, s_pix_rd_en, s_hist_we, s_busy, s_done;
  logic [ADDR_W-1:0] s_num_words, s_pix_addr;
  logic [31:0]       s_pix_data;
  logic [BIN_W-1:0]  s_hist_addr;
  logic [SCW-1:0]    s_hist_data;

  hist_accum_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
    .hist_we(hist_we), .hist_addr(hist_addr), .hist_data(hist_data),
    .busy(busy), .done(done));

  hist_accum_ctrl #(.CNT_W(SCW)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .num_words(s_num_words),
    .pix_rd_en(s_pix_rd_en), .pix_addr(s_pix_addr), .pix_data(s_pix_data),
    .hist_we(s_hist_we), .hist_addr(s_hist_addr), .hist_data(s_hist_data),
    .busy(s_busy), .done(s_done));

  logic [31:0] mem [256];

  // Synchronous-read pixel memory; garbage on the bus when not reading.
  always @(posedge clk) begin
    pix_data   <= pix_rd_en   ? mem[pix_addr[7:0]]   : $urandom;
    s_pix_data <= s_pix_rd_en ? mem[s_pix_addr[7:0]] : $urandom;
  end

  int errs = 0;
  int checks = 0;
  longint exp_hist [NBINS];
  longint got_hist [NBINS];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input int n, input int mode);
    for (int w = 0; w < n; w++) begin
      case (mode)
        0:       mem[w] = 32'h0000_0000;
        1:       mem[w] = 32'hFFFF_FFFF;
        2:       mem[w] = $urandom;
        default: mem[w] = $urandom & 32'h0F0F_0F0F;
      endcase
    end
  endtask

  // Histogram of the top BIN_W bits of every lane pixel, then limited to cw bits.
  task automatic build_model(input int n, input int cw);
    longint mx;
    mx = (longint'(1) << cw) - 1;
    for (int b = 0; b < NBINS; b++) exp_hist[b] = 0;
    for (int w = 0; w < n; w++)
      for (int l = 0; l < LANES; l++) begin
        int pix;
        pix = int'((mem[w] >> (l * PIX_W)) & 32'hFF);
        exp_hist[pix >> (PIX_W - BIN_W)]++;
      end
    for (int b = 0; b < NBINS; b++) begin
`ifdef HIST_SAT_EN
      if (exp_hist[b] > mx) exp_hist[b] = mx;
`else
      exp_hist[b] = exp_hist[b] & mx;
`endif
    end
  endtask

  task automatic run_big(input int n, input string tag);
    int wstart, bad_rd, bad_wr, bad_busy, nrd, nwr, ndone, done_at;
    bad_rd = 0; bad_wr = 0; bad_busy = 0; nrd = 0; nwr = 0; ndone = 0; done_at = -1;
    build_model(n, CNT_W);
    for (int b = 0; b < NBINS; b++) got_hist[b] = -1;
    wstart = (n == 0) ? 1 : n + 2;
    start = 1'b1;
    num_words = ADDR_W'(n);
    @(negedge clk);
    for (int k = 1; k <= wstart + NBINS; k++) begin
      start = (k == 2);
      if (k == 2) num_words = ADDR_W'($urandom_range(1, 20));
      if (pix_rd_en !== logic'(k <= n)) bad_rd++;
      if (pix_rd_en === 1'b1) begin
        nrd++;
        if (pix_addr !== ADDR_W'(k - 1)) bad_rd++;
      end
      if (hist_we !== logic'(k >= wstart && k < wstart + NBINS)) bad_wr++;
      if (hist_we === 1'b1) begin
        nwr++;
        if (hist_addr !== BIN_W'(k - wstart)) bad_wr++;
        got_hist[hist_addr] = longint'(hist_data);
      end
      if (done === 1'b1) begin
        ndone++;
        done_at = k;
      end
      if (busy !== 1'b1) bad_busy++;
      @(negedge clk);
    end
    start = 1'b0;
    check_val($sformatf("%s:rd_seq", tag), bad_rd, 0);
    check_val($sformatf("%s:rd_count", tag), nrd, n);
    check_val($sformatf("%s:wr_seq", tag), bad_wr, 0);
    check_val($sformatf("%s:wr_count", tag), nwr, NBINS);
    check_val($sformatf("%s:done_count", tag), ndone, 1);
    check_val($sformatf("%s:done_cycle", tag), done_at, wstart + NBINS);
    check_val($sformatf("%s:busy_run", tag), bad_busy, 0);
    check_val($sformatf("%s:busy_after", tag), busy, 0);
    for (int b = 0; b < NBINS; b++)
      check_val($sformatf("%s:bin%0d", tag, b), got_hist[b], exp_hist[b]);
  endtask

  task automatic run_small(input int n, input string tag);
    int nwr, done_at;
    nwr = 0; done_at = -1;
    build_model(n, SCW);
    for (int b = 0; b < NBINS; b++) got_hist[b] = -1;
    s_start = 1'b1;
    s_num_words = ADDR_W'(n);
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 1; k <= n + NBINS + 4; k++) begin
      if (s_hist_we === 1'b1) begin
        nwr++;
        got_hist[s_hist_addr] = longint'(s_hist_data);
      end
      if (s_done === 1'b1 && done_at < 0) done_at = k;
      @(negedge clk);
    end
    check_val($sformatf("%s:wr_count", tag), nwr, NBINS);
    check_val($sformatf("%s:done_cycle", tag), done_at, n + NBINS + 2);
    for (int b = 0; b < NBINS; b++)
      check_val($sformatf("%s:bin%0d", tag, b), got_hist[b], exp_hist[b]);
  endtask

  initial begin
    int n, stray;
    rst = 1'b1;
    start = 1'b0; num_words = '0;
    s_start = 1'b0; s_num_words = '0;
    repeat (2) @(negedge clk);
    check_val("rst:pix_rd_en", pix_rd_en, 0);
    check_val("rst:pix_addr", pix_addr, 0);
    check_val("rst:hist_we", hist_we, 0);
    check_val("rst:hist_addr", hist_addr, 0);
    check_val("rst:hist_data", hist_data, 0);
    check_val("rst:busy", busy, 0);
    check_val("rst:done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    fill_mem(4, 0);
    run_big(4, "zeros4");
    check_val("zeros4:bin0_const", got_hist[0], 16);

    // Started in the first IDLE cycle after done: no residue allowed.
    mem[0] = 32'h05FC_0400;
    run_big(1, "lanes1");
    check_val("lanes1:bin1_const", got_hist[1], 2);
    run_big(0, "empty");

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 40);
      fill_mem(n, 2);
      run_big(n, $sformatf("rand%0d", i));
    end

    // Reset in the middle of ACCUM abandons the run.
    fill_mem(10, 2);
    start = 1'b1; num_words = ADDR_W'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst:busy", busy, 0);
    check_val("midrst:pix_rd_en", pix_rd_en, 0);
    check_val("midrst:hist_we", hist_we, 0);
    stray = 0;
    for (int k = 0; k < 80; k++) begin
      if (hist_we !== 1'b0 || busy !== 1'b0 || pix_rd_en !== 1'b0 || done !== 1'b0) stray++;
      @(negedge clk);
    end
    check_val("midrst:quiet", stray, 0);
    fill_mem(2, 1);
    run_big(2, "after_rst");
    check_val("after_rst:bin63_const", got_hist[63], 8);

    fill_mem(2, 0);
    run_small(2, "sat2");
`ifdef HIST_SAT_EN
    check_val("sat2:bin0_const", got_hist[0], 7);
`else
    check_val("sat2:bin0_const", got_hist[0], 0);
`endif
    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(1, 12);
      fill_mem(n, 3);
      run_small(n, $sformatf("small%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
